// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int   PS2_DATA_BITS = 8;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;
  // PS/2 uses odd parity: data bits plus parity bit XOR to 1 on a clean frame.
  localparam logic PARITY_GOOD   = 1'b1;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises one asynchronous PS/2 line and debounces it over FILTER samples.
// Latency: 2 sync cycles plus FILTER cycles from a stable input change to line_flt.
// Backpressure: none; free-running on every clk_sys cycle.
module ps2_line_filter #(
  parameter int FILTER = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic line_in,
  output logic line_flt
);

  localparam int CNT_W = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser; idle level of a PS/2 line is high.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= line_in;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive samples that disagree with the filtered level; flip on the FILTER-th.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      line_flt <= 1'b1;
      cnt      <= '0;
    end else if (sync_q2 == line_flt) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(FILTER - 1)) begin
      line_flt <= sync_q2;
      cnt      <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 receiver: filtered clk/data deserialiser with parity/stop/timeout checks and a show-ahead FIFO.
// Latency: byte appears on rx_data/rx_valid one cycle after the stop-bit sample event.
// Backpressure: rx_ready pops the head; a good byte arriving while full and not popping is dropped and flags overflow.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER    = 4,
  parameter int TIMEOUT   = 16384,
  parameter int FIFO_BITS = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overflow,
  input  logic                 clr_err,
  output logic                 busy,
  output logic [FIFO_BITS:0]   level
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int BIT_W = $clog2(PS2_DATA_BITS);
  localparam int DEPTH = 1 << FIFO_BITS;

  logic clk_flt;
  logic data_flt;
  logic clk_flt_q;
  logic sample;

  ps2_state_t               state, state_nxt;
  logic [BIT_W-1:0]         bit_cnt, bit_cnt_nxt;
  logic [PS2_DATA_BITS-1:0] shreg, shreg_nxt;
  logic                     par_bit, par_bit_nxt;
  logic                     push;
  logic                     perr_nxt;
  logic                     ferr_nxt;
  logic [TMO_W-1:0]         tmo_cnt;
  logic                     tmo_hit;

  logic [7:0]               mem [DEPTH];
  logic [FIFO_BITS:0]       wptr;
  logic [FIFO_BITS:0]       rptr;
  logic                     full;
  logic                     pop;
  logic                     push_ok;

  ps2_line_filter #(.FILTER(FILTER)) u_clk_filter (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .line_in  (ps2_clk),
    .line_flt (clk_flt)
  );

  ps2_line_filter #(.FILTER(FILTER)) u_data_filter (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .line_in  (ps2_data),
    .line_flt (data_flt)
  );

  // Remember the previous filtered clock so a 1->0 transition is seen in one cycle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) clk_flt_q <= 1'b1;
    else          clk_flt_q <= clk_flt;
  end

  assign sample  = clk_flt_q & ~clk_flt;
  assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT));
  assign busy    = (state != IDLE);

  // Inter-bit watchdog: only runs mid-frame, restarted by every sample event.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                        tmo_cnt <= '0;
    else if (sample || state == IDLE)    tmo_cnt <= '0;
    else if (tmo_cnt != TMO_W'(TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Receiver next-state logic; advances on sample events, a sample wins over a same-cycle timeout.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_bit_nxt = par_bit;
    push        = 1'b0;
    perr_nxt    = 1'b0;
    ferr_nxt    = 1'b0;
    if (sample) begin
      case (state)
        IDLE: begin
          if (data_flt == START_BIT) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end else begin
            ferr_nxt = 1'b1;
          end
        end
        DATA: begin
          shreg_nxt = {data_flt, shreg[PS2_DATA_BITS-1:1]};
          if (bit_cnt == BIT_W'(PS2_DATA_BITS - 1)) state_nxt = PARITY;
          else                                      bit_cnt_nxt = bit_cnt + 1'b1;
        end
        PARITY: begin
          par_bit_nxt = data_flt;
          state_nxt   = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          perr_nxt  = ((^{shreg, par_bit}) != PARITY_GOOD);
          ferr_nxt  = (data_flt != STOP_BIT);
          push      = !perr_nxt && (data_flt == STOP_BIT);
        end
        default: state_nxt = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_nxt = IDLE;
      ferr_nxt  = 1'b1;
    end
  end

  // Receiver state and registered one-cycle error pulses.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      par_bit    <= par_bit_nxt;
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
    end
  end

  // FIFO control: extended pointers make level = wptr - rptr range 0..DEPTH.
  assign level    = wptr - rptr;
  assign rx_valid = (level != '0);
  assign full     = (level == (FIFO_BITS + 1)'(DEPTH));
  assign pop      = rx_valid & rx_ready;
  assign push_ok  = push & (~full | pop);
  assign rx_data  = mem[rptr[FIFO_BITS-1:0]];

  // FIFO storage and pointers; reset discards queued bytes so rx_data reads 0.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr[FIFO_BITS-1:0]] <= shreg;
        wptr                     <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  // Sticky overflow; a new drop beats a same-cycle clear.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                  overflow <= 1'b0;
    else if (push & full & ~pop)   overflow <= 1'b1;
    else if (clr_err)              overflow <= 1'b0;
  end

endmodule
